// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - I/D cache to single memory port arbiter with atomic write-back/refill pairs
//
// Purpose:
//   Shares one block-wide memory port between the instruction cache (I side)
//   and the data cache (D side). One side owns the port per transaction.
//   A write-back followed immediately by a refill read from the same side is
//   kept atomic, so the other side cannot slip in between the two halves.
//
// Build option:
//   MEM_ARB_DPRIO_EN - when defined, simultaneous requests always go to D
//                      (fixed priority); otherwise round-robin on last_grant.
//
// Ports:
//   clk, proc_reset              clock (rising edge), synchronous active-high reset
//   i_read/i_write/i_addr/i_wdata  I-cache request
//   i_rdata/i_ready              I-cache response (ready gated by grant)
//   d_read/d_write/d_addr/d_wdata  D-cache request
//   d_rdata/d_ready              D-cache response (ready gated by grant)
//   mem_read/mem_write/mem_addr/mem_wdata  memory request (muxed from granted side)
//   mem_rdata/mem_ready          memory response; mem_ready is a one-cycle done pulse

module mem_arbiter #(
    parameter int ADDR_WIDTH = 28,
    parameter int DATA_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  proc_reset,
    input  logic                  i_read,
    input  logic                  i_write,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] i_rdata,
    output logic                  i_ready,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_ready,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT_I = 2'd1,
        S_GRANT_D = 2'd2
    } state_t;

    state_t r_state;
    logic   r_last_grant;   // 0 = I served last, 1 = D served last
    logic   r_wb_hold;      // granted side just finished a write-back

    state_t w_next_state;
    logic   w_next_last_grant;
    logic   w_next_wb_hold;

    logic   w_req_i;
    logic   w_req_d;
    logic   w_sel_side;     // side owning the port while granted (0 = I, 1 = D)
    logic   w_sel_read;
    logic   w_sel_write;

    assign w_req_i     = i_read | i_write;
    assign w_req_d     = d_read | d_write;
    assign w_sel_side  = (r_state == S_GRANT_D);
    assign w_sel_read  = w_sel_side ? d_read  : i_read;
    assign w_sel_write = w_sel_side ? d_write : i_write;

    // Read data is a shared bus; only the ready strobe is steered.
    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

    // State register
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_wb_hold    <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_last_grant <= w_next_last_grant;
            r_wb_hold    <= w_next_wb_hold;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state      = r_state;
        w_next_last_grant = r_last_grant;
        w_next_wb_hold    = r_wb_hold;
        case (r_state)
            S_IDLE: begin
                w_next_wb_hold = 1'b0;
                if (w_req_i && w_req_d) begin
`ifdef MEM_ARB_DPRIO_EN
                    w_next_state = S_GRANT_D;
`else
                    w_next_state = r_last_grant ? S_GRANT_I : S_GRANT_D;
`endif
                end else if (w_req_i) begin
                    w_next_state = S_GRANT_I;
                end else if (w_req_d) begin
                    w_next_state = S_GRANT_D;
                end
            end
            S_GRANT_I, S_GRANT_D: begin
                if (mem_ready) begin
                    if (w_sel_write) begin
                        // Keep the port for one cycle so a refill can follow.
                        w_next_wb_hold = 1'b1;
                    end else begin
                        w_next_state      = S_IDLE;
                        w_next_last_grant = w_sel_side;
                        w_next_wb_hold    = 1'b0;
                    end
                end else if (r_wb_hold) begin
                    // No refill follows the write-back: the pair is over.
                    if (!w_sel_read) begin
                        w_next_state      = S_IDLE;
                        w_next_last_grant = w_sel_side;
                        w_next_wb_hold    = 1'b0;
                    end
                end else if (!w_sel_read && !w_sel_write) begin
                    // Request withdrawn before completion; fairness untouched.
                    w_next_state   = S_IDLE;
                    w_next_wb_hold = 1'b0;
                end
            end
            default: begin
                w_next_state   = S_IDLE;
                w_next_wb_hold = 1'b0;
            end
        endcase
    end

    // Output logic
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        i_ready   = 1'b0;
        d_ready   = 1'b0;
        case (r_state)
            S_GRANT_I: begin
                mem_addr  = i_addr;
                mem_wdata = i_wdata;
                mem_write = i_write;
                mem_read  = i_read & ~i_write;
                i_ready   = mem_ready;
            end
            S_GRANT_D: begin
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
                mem_write = d_write;
                mem_read  = d_read & ~d_write;
                d_ready   = mem_ready;
            end
            default: begin
                mem_read  = 1'b0;
                mem_write = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter

module tb_mem_arbiter;

    localparam int AW = 28;
    localparam int DW = 128;

    logic          clk = 1'b0;
    logic          proc_reset;
    logic          i_read, i_write, d_read, d_write;
    logic [AW-1:0] i_addr, d_addr, mem_addr;
    logic [DW-1:0] i_wdata, d_wdata, i_rdata, d_rdata, mem_wdata, mem_rdata;
    logic          i_ready, d_ready, mem_read, mem_write, mem_ready;

    int n_vec  = 0;
    int n_fail = 0;
    bit m_last;     // model: side served last (0 = I, 1 = D)

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .proc_reset(proc_reset),
        .i_read(i_read), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_rdata(i_rdata), .i_ready(i_ready),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Winner when both sides contend, from the arbitration policy alone.
    function automatic bit pick(input bit last);
`ifdef MEM_ARB_DPRIO_EN
        return 1'b1;
`else
        return ~last;
`endif
    endfunction

    task automatic drive(input bit side, input bit rd, input bit wr,
                         input logic [AW-1:0] a, input logic [DW-1:0] wd);
        if (side) begin
            d_read = rd; d_write = wr; d_addr = a; d_wdata = wd;
        end else begin
            i_read = rd; i_write = wr; i_addr = a; i_wdata = wd;
        end
    endtask

    task automatic do_reset();
        proc_reset = 1'b1;
        drive(0, 0, 0, '0, '0);
        drive(1, 0, 0, '0, '0);
        mem_ready = 1'b0;
        mem_rdata = '0;
        repeat (2) @(negedge clk);
        proc_reset = 1'b0;
        m_last = 1'b1;
        #1;
        chk("rst_mem_read", mem_read, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_i_ready", i_ready, 0);
        chk("rst_d_ready", d_ready, 0);
        @(negedge clk);
    endtask

    // Called at a negedge with side's request already on its inputs. Acts as
    // the memory: waits for the request, checks it, pulses mem_ready after
    // lat cycles and checks ready steering. Returns at the negedge after the
    // ready pulse, with mem_ready low again.
    task automatic do_txn(input bit side, input bit wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, input int lat,
                          input logic [DW-1:0] rd, output int waited);
        waited = 0;
        #1;
        while (!(mem_read || mem_write) && waited < 20) begin
            @(negedge clk); #1;
            waited++;
        end
        chk("grant_timeout", waited < 20, 1);
        chk("op_write", mem_write, wr);
        chk("op_read", mem_read, !wr);
        chk("op_addr", mem_addr, a);
        if (wr) chk("op_wdata", mem_wdata, wd);
        for (int k = 1; k < lat; k++) begin
            @(negedge clk); #1;
            chk("wait_i_ready", i_ready, 0);
            chk("wait_d_ready", d_ready, 0);
            chk("wait_addr", mem_addr, a);
        end
        @(negedge clk);
        mem_rdata = rd;
        mem_ready = 1'b1;
        #1;
        chk("own_ready", side ? d_ready : i_ready, 1);
        chk("other_ready", side ? i_ready : d_ready, 0);
        chk("i_rdata", i_rdata, rd);
        chk("d_rdata", d_rdata, rd);
        @(negedge clk);
        mem_ready = 1'b0;
    endtask

    // kind 0: read, 1: write-back only, 2: write-back then refill read
    task automatic serve_side(input bit side, input int kind, input logic [AW-1:0] a1,
                              input logic [DW-1:0] wd, input logic [AW-1:0] a2);
        int w;
        logic [DW-1:0] rd;
        rd = {$urandom, $urandom, $urandom, $urandom};
        if (kind == 0) begin
            do_txn(side, 0, a1, '0, $urandom_range(1, 4), rd, w);
        end else begin
            do_txn(side, 1, a1, wd, $urandom_range(1, 4), rd, w);
            if (kind == 2) begin
                drive(side, 1, 0, a2, '0);
                do_txn(side, 0, a2, '0, $urandom_range(1, 4), ~rd, w);
                chk("refill_no_bubble", w, 0);
            end
        end
        drive(side, 0, 0, '0, '0);
        m_last = side;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed hang expected finish");
        $fatal(1);
    end

    initial begin
        int w;
        bit s;

        // 1: single I read, bubble, latency, routing
        do_reset();
        drive(0, 1, 0, 28'h0000010, '0);
        #1 chk("t1_bubble", mem_read, 0);
        do_txn(0, 0, 28'h0000010, '0, 3, 128'hA5, w);
        chk("t1_first_req_latency", w, 1);
        drive(0, 0, 0, '0, '0);
        m_last = 0;
        repeat (2) @(negedge clk);

        // 2: simultaneous reads held continuously
        do_reset();
        drive(0, 1, 0, 28'h0000011, '0);
        drive(1, 1, 0, 28'h0000022, '0);
        for (int g = 0; g < 4; g++) begin
            s = pick(m_last);
            do_txn(s, 0, s ? 28'h0000022 : 28'h0000011, '0, 2, 128'(g + 1), w);
            m_last = s;
        end
        drive(0, 0, 0, '0, '0);
        drive(1, 0, 0, '0, '0);
        repeat (3) @(negedge clk);

        // 3: D write-back + refill atomic against pending I
        do_reset();
        drive(0, 1, 0, 28'h0000033, '0);
        do_txn(0, 0, 28'h0000033, '0, 1, 128'h1, w);
        drive(0, 0, 0, '0, '0);
        m_last = 0;
        repeat (2) @(negedge clk);
        drive(1, 0, 1, 28'h0000100, 128'hDEAD_BEEF);
        drive(0, 1, 0, 28'h0000044, '0);
        serve_side(1, 2, 28'h0000100, 128'hDEAD_BEEF, 28'h0000200);
        do_txn(0, 0, 28'h0000044, '0, 2, 128'h2, w);
        drive(0, 0, 0, '0, '0);
        m_last = 0;
        repeat (2) @(negedge clk);

        // 4: D write with no refill, I pending
        drive(1, 0, 1, 28'h0000300, 128'hCAFE);
        drive(0, 1, 0, 28'h0000055, '0);
        s = pick(m_last);
        chk("t4_model_winner_d", s, 1);
        do_txn(1, 1, 28'h0000300, 128'hCAFE, 2, 128'h3, w);
        drive(1, 0, 0, '0, '0);
        #1 chk("t4_hold_no_read", mem_read, 0);
        do_txn(0, 0, 28'h0000055, '0, 1, 128'h4, w);
        chk("t4_idle_after_wb", w, 2);
        drive(0, 0, 0, '0, '0);
        repeat (2) @(negedge clk);

        // 5: reset while D granted, late ready ignored
        do_reset();
        drive(1, 1, 0, 28'h0000066, '0);
        @(negedge clk); @(negedge clk);
        #1 chk("t5_granted", mem_read, 1);
        @(negedge clk);
        proc_reset = 1'b1;
        @(negedge clk);
        #1;
        chk("t5_rst_mem_read", mem_read, 0);
        chk("t5_rst_mem_write", mem_write, 0);
        chk("t5_rst_d_ready", d_ready, 0);
        @(negedge clk);
        proc_reset = 1'b0;
        drive(1, 0, 0, '0, '0);
        mem_ready = 1'b1;
        #1;
        chk("t5_late_d_ready", d_ready, 0);
        chk("t5_late_i_ready", i_ready, 0);
        @(negedge clk);
        mem_ready = 1'b0;
        m_last = 1;
        #1 chk("t5_idle_read", mem_read, 0);

        // 6: I withdraws, fairness unchanged
        do_reset();
        drive(0, 1, 0, 28'h0000077, '0);
        do_txn(0, 0, 28'h0000077, '0, 1, 128'h5, w);
        drive(0, 0, 0, '0, '0);
        m_last = 0;
        repeat (2) @(negedge clk);
        drive(0, 1, 0, 28'h0000078, '0);
        @(negedge clk);
        #1 chk("t6_granted", mem_read, 1);
        @(negedge clk);
        drive(0, 0, 0, '0, '0);
        @(negedge clk);
        #1 chk("t6_withdraw_idle", mem_read, 0);
        @(negedge clk);
        drive(0, 1, 0, 28'h0000079, '0);
        drive(1, 1, 0, 28'h0000088, '0);
        s = pick(m_last);
        chk("t6_model_favours_d", s, 1);
        serve_side(1, 0, 28'h0000088, '0, '0);
        serve_side(0, 0, 28'h0000079, '0, '0);
        repeat (3) @(negedge clk);

        // 7: randomized contention rounds against the transaction model
        for (int r = 0; r < 40; r++) begin
            int mask, ki, kd;
            logic [AW-1:0] ia1, ia2, da1, da2;
            logic [DW-1:0] iwd, dwd;
            mask = $urandom_range(1, 3);
            ki = $urandom_range(0, 2);
            kd = $urandom_range(0, 2);
            ia1 = AW'($urandom); ia2 = AW'($urandom);
            da1 = AW'($urandom); da2 = AW'($urandom);
            iwd = {$urandom, $urandom, $urandom, $urandom};
            dwd = {$urandom, $urandom, $urandom, $urandom};
            if (mask[0]) drive(0, ki == 0, ki != 0, ia1, iwd);
            if (mask[1]) drive(1, kd == 0, kd != 0, da1, dwd);
            if (mask == 3) begin
                s = pick(m_last);
                if (s) begin
                    serve_side(1, kd, da1, dwd, da2);
                    serve_side(0, ki, ia1, iwd, ia2);
                end else begin
                    serve_side(0, ki, ia1, iwd, ia2);
                    serve_side(1, kd, da1, dwd, da2);
                end
            end else if (mask == 1) begin
                serve_side(0, ki, ia1, iwd, ia2);
            end else begin
                serve_side(1, kd, da1, dwd, da2);
            end
            repeat (3) @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
